// File: rtl/async_sr_pkg.sv
// Shared types and constants for the async set/reset pulse sequencer.
package async_sr_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [1:0] {
        POR   = 2'd0,
        IDLE  = 2'd1,
        PULSE = 2'd2,
        RECOV = 2'd3
    } state_e;

    localparam logic [OP_W-1:0] OP_NOP = 2'b00;
    localparam logic [OP_W-1:0] OP_RST = 2'b01;
    localparam logic [OP_W-1:0] OP_SET = 2'b10;
    localparam logic [OP_W-1:0] OP_ILL = 2'b11;

    // Asserted level of the bank's RSTB/SETB pins.
    localparam logic ASSERT_LVL = 1'b0;

endpackage

// File: rtl/rst_release_sync.sv
// Reset-release synchronizer: clears asynchronously, releases after STAGES rising edges.
module rst_release_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rel_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rel_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_sr_sequencer.sv
// Shapes valid/ready requests into min-width active-low set/reset pulses with a
// clock-enable recovery guard; reset is asserted asynchronously and released synchronously.
module async_sr_sequencer
    import async_sr_pkg::*;
#(
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned RECOV_CYC   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic            CLK,
    input  logic            RSTB,
    input  logic            req_valid,
    input  logic [OP_W-1:0] req_op,
    output logic            req_ready,
    output logic            rstb_o,
    output logic            setb_o,
    output logic            clk_en,
    output logic            done,
    output logic            op_err
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              pend_q, pend_d;
    logic              rstb_q, rstb_d;
    logic              setb_q, setb_d;
    logic              clken_q, clken_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rel;
    logic              last_cnt;

    rst_release_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rel_sync (
        .clk_i  (CLK),
        .rst_ni (RSTB),
        .rel_o  (rel)
    );

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= POR;
            cnt_q   <= PULSE_LD;
            op_q    <= OP_NOP;
            pend_q  <= 1'b0;
            rstb_q  <= ASSERT_LVL;
            setb_q  <= ~ASSERT_LVL;
            clken_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            rstb_q  <= rstb_d;
            setb_q  <= setb_d;
            clken_q <= clken_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign last_cnt = (cnt_q <= CNT_ONE);

    // Next state, then registered outputs decoded from the next state so pins track state exactly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        pend_d  = pend_q;
        rstb_d  = ~ASSERT_LVL;
        setb_d  = ~ASSERT_LVL;
        clken_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            POR: begin
                if (rel) begin
                    if (last_cnt) begin
                        state_d = RECOV;
                        cnt_d   = RECOV_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            IDLE: begin
                // One-cycle accept slot between handshake and pulse start.
                if (pend_q) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                    pend_d  = 1'b0;
                end else if (req_valid && (req_op != OP_NOP)) begin
                    op_d   = req_op;
                    pend_d = 1'b1;
                end
            end
            PULSE: begin
                if (last_cnt) begin
                    state_d = RECOV;
                    cnt_d   = RECOV_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RECOV: begin
                if (last_cnt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = POR;
                cnt_d   = PULSE_LD;
            end
        endcase

        case (state_d)
            POR: begin
                rstb_d = ASSERT_LVL;
            end
            IDLE: begin
                clken_d = 1'b1;
            end
            PULSE: begin
                case (op_d)
                    OP_RST:         rstb_d = ASSERT_LVL;
                    OP_SET, OP_ILL: setb_d = ASSERT_LVL;
                    default:        ;
                endcase
            end
            RECOV: begin
                done_d = (cnt_d == CNT_ONE);
                err_d  = (cnt_d == CNT_ONE) && (state_q != POR) && (op_d == OP_ILL);
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE) && !pend_q;
    assign rstb_o    = rstb_q;
    assign setb_o    = setb_q;
    assign clk_en    = clken_q;
    assign done      = done_q;
    assign op_err    = err_q;

endmodule

// File: tb/tb_async_sr_sequencer.sv
// Self-checking bench: two parameterisations driven by shared random stimulus, checked
// every cycle against a timeline model (expected pin/guard/done windows by cycle offset).
module tb_async_sr_sequencer;
    import async_sr_pkg::*;

    localparam int unsigned SYNC = 2;

    typedef struct packed {
        logic ready;
        logic rstb;
        logic setb;
        logic clk_en;
        logic done;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [1:0] ready, rstb_o, setb_o, clk_en, done, op_err;

    int unsigned since [2];
    bit          por   [2];
    logic [1:0]  mop   [2];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    always #5 clk = ~clk;

    async_sr_sequencer #(.PULSE_CYC(2), .RECOV_CYC(2), .SYNC_STAGES(SYNC), .CNT_W(4)) u_dut_a (
        .CLK(clk), .RSTB(rstb), .req_valid(req_valid), .req_op(req_op),
        .req_ready(ready[0]), .rstb_o(rstb_o[0]), .setb_o(setb_o[0]),
        .clk_en(clk_en[0]), .done(done[0]), .op_err(op_err[0])
    );

    async_sr_sequencer #(.PULSE_CYC(3), .RECOV_CYC(1), .SYNC_STAGES(SYNC), .CNT_W(4)) u_dut_b (
        .CLK(clk), .RSTB(rstb), .req_valid(req_valid), .req_op(req_op),
        .req_ready(ready[1]), .rstb_o(rstb_o[1]), .setb_o(setb_o[1]),
        .clk_en(clk_en[1]), .done(done[1]), .op_err(op_err[1])
    );

    function automatic int unsigned pcyc(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int unsigned rcyc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Expected outputs from the number of edges since the sequence began (reset release or handshake).
    function automatic exp_t model(input int i);
        exp_t        e;
        int unsigned lo_start, lo_end, s;
        logic        idle, low;
        e = '{ready: 1'b0, rstb: 1'b0, setb: 1'b1, clk_en: 1'b0, done: 1'b0, err: 1'b0};
        if (!rstb) return e;
        s        = since[i];
        lo_start = por[i] ? 0 : 2;
        lo_end   = por[i] ? SYNC + pcyc(i) : 2 + pcyc(i);
        idle     = (s >= lo_end + rcyc(i));
        low      = (s >= lo_start) && (s < lo_end);
        e.ready  = idle;
        e.clk_en = idle || (!por[i] && s < lo_start);
        e.rstb   = !(low && (por[i] || mop[i] == 2'b01));
        e.setb   = !(low && !por[i] && mop[i] != 2'b01);
        e.done   = (s == lo_end + rcyc(i) - 1);
        e.err    = e.done && !por[i] && (mop[i] == 2'b11);
        return e;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input int i);
        exp_t e;
        e = model(i);
        if (!rstb) begin
            por[i]   = 1'b1;
            since[i] = 0;
        end else if (e.ready && req_valid && req_op != 2'b00) begin
            por[i]   = 1'b0;
            since[i] = 1;
            mop[i]   = req_op;
        end else if (since[i] < 10000) begin
            since[i]++;
        end
    endtask

    task automatic check_all();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = model(i);
            chk($sformatf("req_ready[%0d]", i), ready[i],  e.ready);
            chk($sformatf("rstb_o[%0d]", i),    rstb_o[i], e.rstb);
            chk($sformatf("setb_o[%0d]", i),    setb_o[i], e.setb);
            chk($sformatf("clk_en[%0d]", i),    clk_en[i], e.clk_en);
            chk($sformatf("done[%0d]", i),      done[i],   e.done);
            chk($sformatf("op_err[%0d]", i),    op_err[i], e.err);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] op);
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        rstb      = r;
        req_valid = v;
        req_op    = op;
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        logic       v;
        logic [1:0] op;
        int         rst_hold;
        for (int i = 0; i < 2; i++) begin
            since[i] = 0;
            por[i]   = 1'b1;
            mop[i]   = 2'b00;
        end

        // Power-on: reset low three cycles, then the POR pulse and guard.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'b00);
        idle_cycles(10);

        // Reset op with valid held through the pulse: one extra sequence once idle again.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 2'b01);
        idle_cycles(8);

        // Illegal op runs as set and flags op_err; then a plain set.
        step(1'b1, 1'b1, 2'b11);
        idle_cycles(8);
        step(1'b1, 1'b1, 2'b10);
        idle_cycles(8);
        step(1'b1, 1'b1, 2'b00);
        idle_cycles(2);

        // Set interrupted by RSTB in its second pulse cycle (instance A), then POR again.
        step(1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        idle_cycles(12);

        v        = 1'b0;
        op       = 2'b00;
        rst_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rst_hold > 0) rst_hold--;
            else if ($urandom_range(0, 249) == 0) rst_hold = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) v = ~v;
            if ($urandom_range(0, 5) == 0) op = 2'($urandom_range(0, 3));
            step(rst_hold == 0, v, op);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
